// File: rtl/i2c_accel_target.sv
// rtl/i2c_accel_target.sv - I2C target emulating the accelerometer register interface
module i2c_accel_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h34,
  parameter logic [7:0] WHOAMI_VAL = 8'h68,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       local_we,
  input  logic [6:0] local_addr,
  input  logic [7:0] local_wdata,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int         CW      = $clog2(FILTER_LEN + 1);
  localparam logic [6:0] RO_ADDR = 7'd117;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_PTR, S_WR_DATA, S_RD_DATA, S_WAIT_STOP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f, scl_p, sda_p;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [6:0]    pointer;
  logic          rw_q;
  logic          mack;
  logic [7:0]    mem [128];

  // Bus idles high, so synchronizers and filters reset to 1 to avoid a false edge.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_p    <= scl_f;
      sda_p    <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CW'(1);
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CW'(1);
      end
    end
  end

  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_det = scl_f & scl_p & ~sda_f & sda_p;
  assign stop_det  = scl_f & scl_p & sda_f & ~sda_p;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // bit_cnt==8: ACK slot being driven; bit_cnt==9: ACK slot clocked, ends on next fall.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: begin
          if (bit_cnt == 4'd8 && shreg[7:1] != DEV_ADDR) state_d = S_WAIT_STOP;
          else if (bit_cnt == 4'd9)                      state_d = rw_q ? S_RD_DATA : S_PTR;
        end
        S_PTR:     if (bit_cnt == 4'd9) state_d = S_WR_DATA;
        S_RD_DATA: if (bit_cnt == 4'd9 && mack) state_d = S_WAIT_STOP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pointer  <= '0;
      rw_q     <= 1'b0;
      mack     <= 1'b1;
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem[107] <= 8'h40;
      mem[117] <= WHOAMI_VAL;
    end else begin
      wr_valid <= 1'b0;
      if (local_we && local_addr != RO_ADDR) mem[local_addr] <= local_wdata;

      if (stop_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_PTR, S_WR_DATA: begin
            if (scl_rise) begin
              if (bit_cnt < 4'd8) begin
                shreg   <= {shreg[6:0], sda_f};
                bit_cnt <= bit_cnt + 4'd1;
              end else if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd9;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (state_q == S_ADDR) begin
                if (shreg[7:1] == DEV_ADDR) begin
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                  rw_q   <= shreg[0];
                end
              end else begin
                sda_oe <= 1'b1;
                if (state_q == S_PTR) begin
                  pointer <= shreg[6:0];
                end else begin
                  // Listed after the local write so a same-address collision resolves to the bus.
                  if (pointer != RO_ADDR) mem[pointer] <= shreg;
                  wr_valid <= 1'b1;
                  wr_addr  <= pointer;
                  wr_data  <= shreg;
                  pointer  <= pointer + 7'd1;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              if (state_q == S_ADDR && rw_q) begin
                shreg   <= mem[pointer];
                sda_oe  <= ~mem[pointer][7];
                pointer <= pointer + 7'd1;
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise) begin
              if (bit_cnt < 4'd8) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else if (bit_cnt == 4'd8) begin
                mack    <= sda_f;
                bit_cnt <= 4'd9;
              end
            end else if (scl_fall) begin
              if (bit_cnt >= 4'd1 && bit_cnt <= 4'd7) begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], 1'b0};
              end else if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
              end else if (bit_cnt == 4'd9) begin
                bit_cnt <= '0;
                if (!mack) begin
                  shreg   <= mem[pointer];
                  sda_oe  <= ~mem[pointer][7];
                  pointer <= pointer + 7'd1;
                end else begin
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_accel_target.sv
// tb/tb_i2c_accel_target.sv - directed bench for i2c_accel_target
module tb_i2c_accel_target;
  localparam int Q = 10;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       scl;
  logic       m_sda;
  logic       local_we;
  logic [6:0] local_addr;
  logic [7:0] local_wdata;
  logic       sda_oe, wr_valid, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_line = m_sda & ~sda_oe;

  int checks = 0;
  int failures = 0;
  int oe_cycles = 0;
  int wr_count = 0;
  logic [6:0] wa_log [256];
  logic [7:0] wd_log [256];
  logic [7:0] rd_buf [16];
  logic [7:0] wr_buf [8];
  logic       acks_ok;

  i2c_accel_target dut (
    .clk_in(clk_in), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .local_we(local_we), .local_addr(local_addr), .local_wdata(local_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (sda_oe) oe_cycles++;
    if (wr_valid) begin
      wa_log[wr_count[7:0]] = wr_addr;
      wd_log[wr_count[7:0]] = wr_data;
      wr_count++;
    end
  end

  task automatic hq(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic i2c_start;
    if (!scl) begin
      m_sda = 1'b1; hq(Q); scl = 1'b1; hq(Q);
    end
    m_sda = 1'b0; hq(Q); scl = 1'b0; hq(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; hq(Q); scl = 1'b1; hq(Q); m_sda = 1'b1; hq(Q);
  endtask

  task automatic send_bits8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; hq(Q); scl = 1'b1; hq(Q); scl = 1'b0; hq(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits8(b);
    m_sda = 1'b1; hq(Q); scl = 1'b1; hq(Q / 2);
    ack = ~sda_line;
    hq(Q / 2); scl = 1'b0; hq(Q);
  endtask

  task automatic read_byte(input logic do_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; hq(Q); scl = 1'b1; hq(Q / 2);
      b[i] = sda_line;
      hq(Q / 2); scl = 1'b0; hq(Q);
    end
    m_sda = ~do_ack; hq(Q); scl = 1'b1; hq(Q); scl = 1'b0; hq(Q);
    m_sda = 1'b1;
  endtask

  task automatic i2c_write(input int n);
    logic a;
    i2c_start;
    write_byte(8'h68, a); acks_ok = a;
    for (int k = 0; k < n; k++) begin
      write_byte(wr_buf[k], a); acks_ok = acks_ok & a;
    end
    i2c_stop;
  endtask

  task automatic read_seq(input logic [6:0] ptr, input int n);
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start; write_byte(8'h68, a0); write_byte({1'b0, ptr}, a1);
    i2c_start; write_byte(8'h69, a2);
    acks_ok = a0 & a1 & a2;
    for (int k = 0; k < n; k++) begin
      read_byte(k != n - 1, d); rd_buf[k] = d;
    end
    i2c_stop;
  endtask

  task automatic local_write(input logic [6:0] a, input logic [7:0] d);
    local_we = 1'b1; local_addr = a; local_wdata = d; hq(1);
    local_we = 1'b0; hq(1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
    local_we = 1'b0; local_addr = '0; local_wdata = '0;
    hq(4); reset_n = 1'b1; hq(4);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (wr_addr !== 7'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_whoami_read;
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start; write_byte(8'h68, a0); write_byte(8'h75, a1);
    i2c_start; write_byte(8'h69, a2); read_byte(1'b0, d);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL whoami_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (d !== 8'h68) begin failures++; $display("FAIL whoami_data got=%h exp=68", d); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL whoami_release got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL whoami_busy got=%b exp=1", busy); end
    i2c_stop;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL whoami_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_write_multi;
    int w0;
    logic a;
    w0 = wr_count;
    i2c_start; write_byte(8'h68, a); acks_ok = a;
    write_byte(8'h1A, a); acks_ok = acks_ok & a;
    write_byte(8'h01, a); acks_ok = acks_ok & a;
    write_byte(8'h02, a); acks_ok = acks_ok & a;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
    i2c_stop;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
    checks++; if (acks_ok !== 1'b1) begin failures++; $display("FAIL wr_acks got=%b exp=1", acks_ok); end
    checks++; if (wr_count - w0 !== 2) begin failures++; $display("FAIL wr_pulses got=%0d exp=2", wr_count - w0); end
    checks++; if ({wa_log[w0[7:0]], wd_log[w0[7:0]]} !== {7'h1A, 8'h01})
      begin failures++; $display("FAIL wr_pulse0 got=%h/%h exp=1a/01", wa_log[w0[7:0]], wd_log[w0[7:0]]); end
    checks++; if ({wa_log[w0[7:0] + 8'd1], wd_log[w0[7:0] + 8'd1]} !== {7'h1B, 8'h02})
      begin failures++; $display("FAIL wr_pulse1 got=%h/%h exp=1b/02", wa_log[w0[7:0] + 8'd1], wd_log[w0[7:0] + 8'd1]); end
    read_seq(7'h1A, 2);
    checks++; if ({rd_buf[0], rd_buf[1]} !== 16'h0102) begin failures++; $display("FAIL wr_readback got=%h%h exp=0102", rd_buf[0], rd_buf[1]); end
  endtask

  task automatic test_wrong_addr;
    int o0;
    logic a;
    o0 = oe_cycles;
    i2c_start; write_byte(8'h6A, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL badaddr_ack got=%b exp=0", a); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL badaddr_busy got=%b exp=0", busy); end
    write_byte(8'h10, a);
    i2c_stop;
    checks++; if (oe_cycles !== o0) begin failures++; $display("FAIL badaddr_oe got=%0d exp=%0d", oe_cycles, o0); end
    wr_buf[0] = 8'h10; wr_buf[1] = 8'h77;
    i2c_write(2);
    checks++; if (acks_ok !== 1'b1) begin failures++; $display("FAIL badaddr_next_acks got=%b exp=1", acks_ok); end
    read_seq(7'h10, 1);
    checks++; if (rd_buf[0] !== 8'h77) begin failures++; $display("FAIL badaddr_next_data got=%h exp=77", rd_buf[0]); end
  endtask

  task automatic test_burst_read;
    logic [7:0] e;
    for (int k = 0; k < 14; k++) local_write(7'(59 + k), 8'(8'h10 + k));
    read_seq(7'h3B, 14);
    checks++; if (acks_ok !== 1'b1) begin failures++; $display("FAIL burst_acks got=%b exp=1", acks_ok); end
    for (int k = 0; k < 14; k++) begin
      e = 8'(8'h10 + k);
      checks++; if (rd_buf[k] !== e) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", k, rd_buf[k], e); end
    end
  endtask

  task automatic test_wrap;
    wr_buf[0] = 8'h7F; wr_buf[1] = 8'hAA; wr_buf[2] = 8'hBB;
    i2c_write(3);
    checks++; if (acks_ok !== 1'b1) begin failures++; $display("FAIL wrap_acks got=%b exp=1", acks_ok); end
    read_seq(7'h7F, 2);
    checks++; if (rd_buf[0] !== 8'hAA) begin failures++; $display("FAIL wrap_reg127 got=%h exp=aa", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'hBB) begin failures++; $display("FAIL wrap_reg0 got=%h exp=bb", rd_buf[1]); end
  endtask

  task automatic test_readonly;
    int w0;
    local_write(7'd117, 8'h00);
    w0 = wr_count;
    wr_buf[0] = 8'h75; wr_buf[1] = 8'h55;
    i2c_write(2);
    checks++; if (acks_ok !== 1'b1) begin failures++; $display("FAIL ro_acks got=%b exp=1", acks_ok); end
    checks++; if (wr_count - w0 !== 1) begin failures++; $display("FAIL ro_pulses got=%0d exp=1", wr_count - w0); end
    checks++; if ({wa_log[w0[7:0]], wd_log[w0[7:0]]} !== {7'h75, 8'h55})
      begin failures++; $display("FAIL ro_pulse got=%h/%h exp=75/55", wa_log[w0[7:0]], wd_log[w0[7:0]]); end
    read_seq(7'h75, 1);
    checks++; if (rd_buf[0] !== 8'h68) begin failures++; $display("FAIL ro_value got=%h exp=68", rd_buf[0]); end
  endtask

  task automatic test_reset_mid_ack;
    i2c_start; send_bits8(8'h68);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rst_ack_driven got=%b exp=1", sda_oe); end
    reset_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_async_release got=%b exp=0", sda_oe); end
    hq(3); reset_n = 1'b1; hq(3);
    i2c_stop;
    read_seq(7'd107, 1);
    checks++; if (rd_buf[0] !== 8'h40) begin failures++; $display("FAIL rst_reg107 got=%h exp=40", rd_buf[0]); end
    read_seq(7'h1A, 1);
    checks++; if (rd_buf[0] !== 8'h00) begin failures++; $display("FAIL rst_reg26 got=%h exp=00", rd_buf[0]); end
  endtask

  initial begin
    test_reset;
    test_whoami_read;
    test_write_multi;
    test_wrong_addr;
    test_burst_read;
    test_wrap;
    test_readonly;
    test_reset_mid_ack;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
